// File: rtl/measure_pkg.sv
// Shared definitions for the period-measurement path (pulse_gen, stb_gen, CSR block).
`timescale 1ns/1ps
package measure_pkg;

    localparam int T_CNT_WIDTH_DEF = 12;
    localparam int N_CNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DELAY = 2'd3
    } pulse_gen_state_e;

    // Operands are zero-extended to 32 bits so any counter width up to 32 can share this check.
    function automatic logic cfg_valid(input logic [31:0] period, input logic [31:0] width);
        return (period >= 32'd2) && (width >= 32'd1) && (width < period);
    endfunction

endpackage

// File: rtl/pulse_gen_timer.sv
// Phase counter for pulse_gen: counts 0..period-1 while enabled, flags the high window and the wrap.
`timescale 1ns/1ps
module pulse_gen_timer
    import measure_pkg::*;
#(
    parameter int T_CNT_WIDTH = T_CNT_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   en_i,
    input  logic [T_CNT_WIDTH-1:0] period_i,
    input  logic [T_CNT_WIDTH-1:0] width_i,
    output logic                   high_o,
    output logic                   wrap_o
);

    logic [T_CNT_WIDTH-1:0] r_phase;
    logic                   w_last;

    // Exact equality against period-1 keeps successive wraps exactly period cycles apart.
    assign w_last = (r_phase == (period_i - 1'b1));
    assign wrap_o = en_i && w_last;
    assign high_o = (r_phase < width_i);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_phase <= '0;
        end else if (!en_i || w_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// Programmable periodic pulse source with finite/continuous bursts and graceful stop.
// Optional start-phase delay (phase_i port, DELAY state) enabled by defining PULSE_GEN_PHASE_EN.
`timescale 1ns/1ps
module pulse_gen
    import measure_pkg::*;
#(
    parameter int T_CNT_WIDTH = T_CNT_WIDTH_DEF,
    parameter int N_CNT_WIDTH = N_CNT_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [T_CNT_WIDTH-1:0] period_i,
    input  logic [T_CNT_WIDTH-1:0] width_i,
    input  logic [N_CNT_WIDTH-1:0] count_i,
`ifdef PULSE_GEN_PHASE_EN
    input  logic [T_CNT_WIDTH-1:0] phase_i,
`endif
    output logic                   sig_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [N_CNT_WIDTH-1:0] pulse_cnt_o
);

    pulse_gen_state_e       r_state, w_state_nxt;
    logic [T_CNT_WIDTH-1:0] r_period, r_width;
    logic [N_CNT_WIDTH-1:0] r_count, r_pulse_cnt, w_cnt_inc;
    logic                   r_sig, r_busy, r_done, r_err;
    logic                   w_cfg_ok, w_accept, w_reject, w_end, w_last_pulse;
    logic                   w_tmr_en, w_high, w_wrap;
`ifdef PULSE_GEN_PHASE_EN
    logic [T_CNT_WIDTH-1:0] r_dly;
`endif

    assign w_tmr_en = (r_state == RUN) || (r_state == DRAIN);

    pulse_gen_timer #(.T_CNT_WIDTH(T_CNT_WIDTH)) u_timer (
        .clk_i    (clk_i),
        .arst_ni  (arst_ni),
        .en_i     (w_tmr_en),
        .period_i (r_period),
        .width_i  (r_width),
        .high_o   (w_high),
        .wrap_o   (w_wrap)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_end        = 1'b0;
        w_cfg_ok     = cfg_valid(32'(period_i), 32'(width_i));
        // Saturating increment keeps continuous mode from wrapping the pulse count.
        w_cnt_inc    = (&r_pulse_cnt) ? r_pulse_cnt : r_pulse_cnt + 1'b1;
        w_last_pulse = (r_count != '0) && (w_cnt_inc == r_count);
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (w_cfg_ok) begin
                        w_accept = 1'b1;
`ifdef PULSE_GEN_PHASE_EN
                        w_state_nxt = (phase_i != '0) ? DELAY : RUN;
`else
                        w_state_nxt = RUN;
`endif
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            RUN: begin
                // A stop sampled on the wrap edge finishes with the period that just completed.
                if (w_wrap && (w_last_pulse || stop_i)) begin
                    w_state_nxt = IDLE;
                    w_end       = 1'b1;
                end else if (stop_i) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_wrap) begin
                    w_state_nxt = IDLE;
                    w_end       = 1'b1;
                end
            end
`ifdef PULSE_GEN_PHASE_EN
            DELAY: begin
                if (stop_i) begin
                    w_state_nxt = IDLE;
                    w_end       = 1'b1;
                end else if (r_dly == 1) begin
                    w_state_nxt = RUN;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered one cycle behind the phase counter, so sig_o rises one clock after the start edge.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_sig       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_pulse_cnt <= '0;
            r_period    <= '0;
            r_width     <= '0;
            r_count     <= '0;
        end else begin
            r_sig  <= w_tmr_en && w_high;
            r_busy <= (r_state != IDLE) && !w_end;
            r_done <= w_end;
            if (w_accept) begin
                r_period    <= period_i;
                r_width     <= width_i;
                r_count     <= count_i;
                r_pulse_cnt <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_reject) begin
                    r_err <= 1'b1;
                end
                if (w_wrap) begin
                    r_pulse_cnt <= w_cnt_inc;
                end
            end
        end
    end

`ifdef PULSE_GEN_PHASE_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_dly <= '0;
        end else if (w_accept) begin
            r_dly <= phase_i;
        end else if (r_state == DELAY) begin
            r_dly <= r_dly - 1'b1;
        end
    end
`endif

    assign sig_o       = r_sig;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign pulse_cnt_o = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: config table, per-cycle scoreboard and edge-timing monitor.
`timescale 1ns/1ps
module tb_pulse_gen;
    import measure_pkg::*;

    localparam int TW = 12;
    localparam int NW = 16;
    localparam int NO_END = 32'h7fffffff;

    logic          clk    = 1'b0;
    logic          arst_n = 1'b0;
    logic          start  = 1'b0;
    logic          stop   = 1'b0;
    logic [TW-1:0] period = '0;
    logic [TW-1:0] width  = '0;
    logic [NW-1:0] count  = '0;
`ifdef PULSE_GEN_PHASE_EN
    logic [TW-1:0] phase  = '0;
`endif
    logic          sig, busy, done, err;
    logic [NW-1:0] pcnt;

    always #4 clk = ~clk;

    pulse_gen #(.T_CNT_WIDTH(TW), .N_CNT_WIDTH(NW)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .start_i     (start),
        .stop_i      (stop),
        .period_i    (period),
        .width_i     (width),
        .count_i     (count),
`ifdef PULSE_GEN_PHASE_EN
        .phase_i     (phase),
`endif
        .sig_o       (sig),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .pulse_cnt_o (pcnt)
    );

    typedef struct {
        logic sig;
        logic busy;
        logic done;
        int   cnt;
        int   k;
    } exp_t;

    typedef struct {
        int   p;
        int   w;
        int   n;
        logic err;
    } vec_t;

    exp_t sb[$];
    exp_t sb_e;
    time  rise_q[$];
    time  hw_q[$];
    time  t_e0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: each pushed record describes the outputs after one clock edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_e = sb.pop_front();
            check($sformatf("sig[k=%0d]", sb_e.k), 64'(sig), 64'(sb_e.sig));
            check($sformatf("busy[k=%0d]", sb_e.k), 64'(busy), 64'(sb_e.busy));
            check($sformatf("done[k=%0d]", sb_e.k), 64'(done), 64'(sb_e.done));
            check($sformatf("pcnt[k=%0d]", sb_e.k), 64'(pcnt), 64'(sb_e.cnt));
        end
    end

    always @(posedge sig) rise_q.push_back($time);
    always @(negedge sig) if (rise_q.size() > 0) hw_q.push_back($time - rise_q[$]);

    // Outputs after edge k (k=0 is the start edge): delay d, then pulses of period p, high w, ending at kend.
    function automatic exp_t model(input int k, input int p, input int w, input int d, input int kend);
        exp_t e;
        int   kk;
        kk = k - d;
        e.k = k;
        if (k == 0) begin
            e.sig = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.cnt = 0;
        end else if (kk <= 0) begin
            e.sig = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.cnt = 0;
        end else if (kk < kend) begin
            e.sig = (((kk - 1) % p) < w); e.busy = 1'b1; e.done = 1'b0; e.cnt = kk / p;
        end else if (kk == kend) begin
            e.sig = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.cnt = kend / p;
        end else begin
            e.sig = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.cnt = kend / p;
        end
        return e;
    endfunction

    // stop_at: edge (relative to the first pulse) where stop is sampled; 0 = together with start; -1 = never.
    task automatic run_burst(input int p, input int w, input int n, input int d,
                             input int stop_at, input int restart_at, input int run_len);
        int kend, se, total_k;
        kend = (n != 0) ? n * p : NO_END;
        if (stop_at >= 1) begin
            se = ((stop_at + p - 1) / p) * p;
            if (se < kend) kend = se;
        end
        total_k = (kend == NO_END) ? run_len : kend + d + 3;
        @(negedge clk);
        period = TW'(p);
        width  = TW'(w);
        count  = NW'(n);
`ifdef PULSE_GEN_PHASE_EN
        phase  = TW'(d);
`endif
        start  = 1'b1;
        stop   = (stop_at == 0);
        @(posedge clk);
        t_e0 = $time;
        sb.push_back(model(0, p, w, d, kend));
        #1;
        for (int k = 1; k <= total_k; k++) begin
            stop  = (stop_at >= 1) && ((k - d) == stop_at);
            start = (k == restart_at);
            if (k == restart_at) begin
                period = TW'(p + 7);
                width  = TW'(1);
            end
            @(posedge clk);
            sb.push_back(model(k, p, w, d, kend));
            #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_edges(input string name, input int rb, input int hb, input int n,
                               input int p, input int w, input int first_ns);
        check({name, "_rises"}, 64'(rise_q.size() - rb), 64'(n));
        if (rise_q.size() >= rb + n && hw_q.size() >= hb + n) begin
            check({name, "_first"}, 64'(rise_q[rb] - t_e0), 64'(first_ns));
            for (int j = 0; j < n; j++) begin
                check($sformatf("%s_high%0d", name, j), 64'(hw_q[hb + j]), 64'(8 * w));
                if (j + 1 < n)
                    check($sformatf("%s_space%0d", name, j), 64'(rise_q[rb + j + 1] - rise_q[rb + j]), 64'(8 * p));
            end
        end
    endtask

    initial begin
        vec_t vec[7];
        int   rb, hb;
        vec[0] = '{p: 10,   w: 10,   n: 1, err: 1'b1};
        vec[1] = '{p: 1,    w: 1,    n: 1, err: 1'b1};
        vec[2] = '{p: 20,   w: 0,    n: 1, err: 1'b1};
        vec[3] = '{p: 2,    w: 1,    n: 3, err: 1'b0};
        vec[4] = '{p: 125,  w: 37,   n: 4, err: 1'b0};
        vec[5] = '{p: 4095, w: 4094, n: 1, err: 1'b0};
        vec[6] = '{p: 7,    w: 3,    n: 2, err: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sig", 64'(sig), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_pcnt", 64'(pcnt), 0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (vec[i].err) begin
                @(negedge clk);
                period = TW'(vec[i].p);
                width  = TW'(vec[i].w);
                count  = NW'(vec[i].n);
                start  = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check($sformatf("bad%0d_err", i), 64'(err), 1);
                    check($sformatf("bad%0d_sig", i), 64'(sig), 0);
                    check($sformatf("bad%0d_busy", i), 64'(busy), 0);
                end
            end else begin
                rb = rise_q.size();
                hb = hw_q.size();
                run_burst(vec[i].p, vec[i].w, vec[i].n, 0, -1, -1, 0);
                check($sformatf("vec%0d_err", i), 64'(err), 0);
                check($sformatf("vec%0d_busy", i), 64'(busy), 0);
                check($sformatf("vec%0d_pcnt", i), 64'(pcnt), 64'(vec[i].n));
                check_edges($sformatf("vec%0d", i), rb, hb, vec[i].n, vec[i].p, vec[i].w, 8);
            end
        end

        // Continuous mode, stop sampled during phase 5 of pulse 7.
        rb = rise_q.size();
        hb = hw_q.size();
        run_burst(50, 10, 0, 0, 6 * 50 + 6, -1, 0);
        check("cont_pcnt", 64'(pcnt), 7);
        check_edges("cont", rb, hb, 7, 50, 10, 8);

        // Second start mid-burst with a different period must not disturb the burst.
        rb = rise_q.size();
        hb = hw_q.size();
        run_burst(30, 12, 3, 0, -1, 40, 0);
        check_edges("rstart", rb, hb, 3, 30, 12, 8);

        // Stop during the final period, and stop together with start in IDLE.
        run_burst(10, 4, 3, 0, 25, -1, 0);
        check("stoplast_pcnt", 64'(pcnt), 3);
        run_burst(6, 2, 2, 0, 0, -1, 0);
        check("startstop_pcnt", 64'(pcnt), 2);

        // Stop in IDLE does nothing.
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("idlestop_busy", 64'(busy), 0);
            check("idlestop_done", 64'(done), 0);
            check("idlestop_sig", 64'(sig), 0);
        end

        // Long period as seen by a loopback measurement.
        rb = rise_q.size();
        hb = hw_q.size();
        run_burst(2500, 1250, 2, 0, -1, -1, 0);
        check_edges("loop", rb, hb, 2, 2500, 1250, 8);

        // Asynchronous reset while sig_o is high, between clock edges.
        @(negedge clk);
        period = 12'd20;
        width  = 12'd10;
        count  = '0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (44) @(posedge clk);
        #2;
        check("arst_pre_sig", 64'(sig), 1);
        check("arst_pre_pcnt", 64'(pcnt), 2);
        arst_n = 1'b0;
        #1;
        check("arst_sig", 64'(sig), 0);
        check("arst_busy", 64'(busy), 0);
        check("arst_pcnt", 64'(pcnt), 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("arst_post_sig", 64'(sig), 0);

`ifdef PULSE_GEN_PHASE_EN
        rb = rise_q.size();
        hb = hw_q.size();
        run_burst(10, 3, 1, 7, -1, -1, 0);
        check_edges("phase", rb, hb, 1, 10, 3, 64);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
